// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the 3-bit select of an 8-way mux, with registered grant.
// Define ARB_LOCK_EN to keep the grant on one requester until it flags the last word of a packet.
module mux8_rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  last,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  gnt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  ack
);

  if (N != 8 || SW != 3) begin : g_bad_cfg
    $error("mux8_rr_arbiter: N must be 8 and SW must be 3");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  // First set bit of vec searching start, start+1, ... modulo N; MSB flags a hit.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] vec, input logic [SW-1:0] start);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = start + SW'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  state_t        state, state_n;
  logic [SW-1:0] ptr, ptr_n, sel_n;
  logic [N-1:0]  gnt_n;
  logic          valid_n;
  logic          rearb;

  logic          accept_c;
  logic [SW-1:0] nxt_ptr_c;
  logic [N-1:0]  sel_dec_c;
  logic [SW:0]   pick_req_c, pick_nxt_c;

`ifdef ARB_LOCK_EN
  logic lock, lock_n;
`else
  logic [N-1:0] unused_last;
  assign unused_last = last;
`endif

  assign accept_c   = out_valid & out_ready;
  assign nxt_ptr_c  = sel + SW'(1);
  assign sel_dec_c  = N'(1) << sel;
  assign pick_req_c = rr_pick(req, ptr);
  // Excluding the accepted index lets it win again only when it is alone.
  assign pick_nxt_c = rr_pick(req & ~sel_dec_c, nxt_ptr_c);
  assign ack        = gnt & {N{accept_c}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
`ifdef ARB_LOCK_EN
      lock      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      out_valid <= valid_n;
`ifdef ARB_LOCK_EN
      lock      <= lock_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    valid_n = out_valid;
    rearb   = 1'b0;
`ifdef ARB_LOCK_EN
    lock_n  = lock;
`endif
    case (state)
      IDLE: begin
        if (pick_req_c[SW]) begin
          sel_n   = pick_req_c[SW-1:0];
          gnt_n   = N'(1) << pick_req_c[SW-1:0];
          valid_n = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        rearb = accept_c;
`ifdef ARB_LOCK_EN
        // Mid-packet: stay on the same requester, valid tracks its request.
        if (accept_c ? !last[sel] : lock) begin
          rearb   = 1'b0;
          lock_n  = 1'b1;
          valid_n = req[sel];
          gnt_n   = req[sel] ? sel_dec_c : '0;
        end else if (accept_c) begin
          lock_n  = 1'b0;
        end
`endif
        if (rearb) begin
          ptr_n = nxt_ptr_c;
          if (pick_nxt_c[SW]) begin
            sel_n   = pick_nxt_c[SW-1:0];
            gnt_n   = N'(1) << pick_nxt_c[SW-1:0];
            valid_n = 1'b1;
          end else if (req[sel]) begin
            gnt_n   = sel_dec_c;
            valid_n = 1'b1;
          end else begin
            gnt_n   = '0;
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  logic chk_hold_c;
`ifdef ARB_LOCK_EN
  assign chk_hold_c = out_valid & ~out_ready & ~lock;
`else
  assign chk_hold_c = out_valid & ~out_ready;
`endif
  // A granted word that is still waiting must keep its request asserted.
  a_req_held: assert property (@(posedge clk) disable iff (rst) chk_hold_c |=> req[sel])
    else $error("mux8_rr_arbiter: req[%0d] dropped while granted", sel);
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: expected acks queue up with the stimulus,
// a negedge monitor pops one per observed ack; per-cycle checks cover reset, latency and holds.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] last;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ack;

  int n_cmp;
  int n_bad;
  int acks_seen;
  int base_acks;
  int mon_idx;
  int exp_q[$];

  mux8_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic cycle_in(input logic [7:0] r, input logic [7:0] l, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    req       = r;
    last      = l;
    out_ready = rdy;
    rst       = rs;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle_in(8'h00, 8'h00, 1'b0, 1'b1);
    check("reset_cycle_ack", 32'(ack), 32'h0);
  endtask

  // Monitor: every observed ack must match the next expected winner.
  always @(negedge clk) begin
    if (ack !== 8'h00) begin
      acks_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack=%0h sel=%0d, expected no ack", ack, sel);
      end else begin
        mon_idx = exp_q.pop_front();
        check("ack_sel", 32'(sel), 32'(mon_idx));
        check("ack_onehot", 32'(ack), 32'(1) << mon_idx);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    acks_seen = 0;
    base_acks = 0;
    rst = 1'b1;
    req = 8'h00;
    last = 8'h00;
    out_ready = 1'b0;

    // Reset, then idle
    cycle_in(8'h00, 8'h00, 1'b0, 1'b1);
    cycle_in(8'h00, 8'h00, 1'b0, 1'b1);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    repeat (2) begin
      cycle_in(8'h00, 8'h00, 1'b1, 1'b0);
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_ack", 32'(ack), 32'h0);
    end

    // Single requester 5: one-cycle latency, re-granted while alone
    exp_q.push_back(5);
    exp_q.push_back(5);
    cycle_in(8'h20, 8'h00, 1'b1, 1'b0);
    check("single_latency_valid", 32'(out_valid), 32'h0);
    cycle_in(8'h20, 8'h00, 1'b1, 1'b0);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_sel", 32'(sel), 32'h5);
    check("single_gnt", 32'(gnt), 32'h20);
    check("single_ack", 32'(ack), 32'h20);
    cycle_in(8'h20, 8'h00, 1'b1, 1'b0);
    check("single_regrant_sel", 32'(sel), 32'h5);
    do_reset();

    // Backpressure holds grant 0, release moves on to 7
    cycle_in(8'h81, 8'h00, 1'b0, 1'b0);
    check("bp_pre_valid", 32'(out_valid), 32'h0);
    repeat (4) begin
      cycle_in(8'h81, 8'h00, 1'b0, 1'b0);
      check("bp_sel", 32'(sel), 32'h0);
      check("bp_gnt", 32'(gnt), 32'h01);
      check("bp_ack", 32'(ack), 32'h0);
    end
    exp_q.push_back(0);
    exp_q.push_back(7);
    cycle_in(8'h81, 8'h00, 1'b1, 1'b0);
    check("bp_release_ack", 32'(ack), 32'h01);
    cycle_in(8'h80, 8'h00, 1'b1, 1'b0);
    check("bp_next_sel", 32'(sel), 32'h7);
    do_reset();

    // Full rotation with all requesting: 0..7 twice, no bubble
    for (int k = 0; k < 16; k++) exp_q.push_back(k % 8);
    cycle_in(8'hFF, 8'h00, 1'b1, 1'b0);
    base_acks = acks_seen;
    for (int k = 0; k < 16; k++) begin
      cycle_in(8'hFF, 8'h00, 1'b1, 1'b0);
      check("rot_valid", 32'(out_valid), 32'h1);
    end
    do_reset();
    check("rot_ack_count", 32'(acks_seen - base_acks), 32'd16);

    // Pointer wrap: after 6 is accepted, ptr=7 so 0 wins over 6
    exp_q.push_back(6);
    exp_q.push_back(0);
    exp_q.push_back(6);
    cycle_in(8'h40, 8'h00, 1'b1, 1'b0);
    cycle_in(8'h41, 8'h00, 1'b1, 1'b0);
    check("wrap_first_sel", 32'(sel), 32'h6);
    cycle_in(8'h41, 8'h00, 1'b1, 1'b0);
    check("wrap_sel", 32'(sel), 32'h0);
    cycle_in(8'h41, 8'h00, 1'b1, 1'b0);
    check("wrap_back_sel", 32'(sel), 32'h6);
    do_reset();

    // Requester 1 sends a 3-word packet while 2 also requests
`ifdef ARB_LOCK_EN
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(2);
`else
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(1);
    exp_q.push_back(2);
`endif
    cycle_in(8'h06, 8'h00, 1'b1, 1'b0);
    cycle_in(8'h06, 8'h00, 1'b1, 1'b0);
    check("pkt_first_sel", 32'(sel), 32'h1);
    cycle_in(8'h06, 8'h00, 1'b1, 1'b0);
    cycle_in(8'h06, 8'h02, 1'b1, 1'b0);
    cycle_in(8'h06, 8'h00, 1'b1, 1'b0);
    check("pkt_after_sel", 32'(sel), 32'h2);
    do_reset();

    cycle_in(8'h00, 8'h00, 1'b0, 1'b0);
    check("post_valid", 32'(out_valid), 32'h0);
    cycle_in(8'h00, 8'h00, 1'b0, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
